// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Fetch program-counter sequencer for the single-issue core. Owns the fetch
// PC, advances it under a request/acknowledge handshake with instruction
// memory, redirects fetch to the resolved EX target on a taken branch/jump,
// flushes wrong-path IF/ID instructions, flags misaligned targets and counts
// accepted redirects.
//
// Optional feature macro: REDIRECT_BYPASS_EN
//   defined   : target is driven onto o_pc combinationally in the resolve
//               cycle, an ack in that cycle is honoured, FLUSH is skipped.
//   undefined : target is registered, one FLUSH cycle follows the redirect.
//
// Parameters
//   XLEN        PC / target width
//   RESET_PC    PC value loaded by reset
//
// Ports
//   i_clk        core clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_ex_valid   EX holds a valid instruction
//   i_ex_ctrl    EX instruction is a branch or jump
//   i_jump_cntr  taken decision for the EX instruction
//   i_ex_target  resolved target address
//   i_stall      hazard stall, EX and PC hold
//   i_fetch_ack  instruction memory accepts o_pc this cycle
//   o_fetch_req  fetch request at o_pc
//   o_pc         fetch address
//   o_flush      kill instructions in IF and ID
//   o_redirect   one-cycle pulse, redirect accepted
//   o_misalign   one-cycle pulse, taken target not word aligned
//   o_taken_cnt  count of accepted redirects (wraps)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | sequential fetch, EX resolve events recognised
// FLUSH  | one cycle after a registered redirect, EX is a bubble, IF/ID killed
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_valid,
    input  logic            i_ex_ctrl,
    input  logic            i_jump_cntr,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_stall,
    input  logic            i_fetch_ack,
    output logic            o_fetch_req,
    output logic [XLEN-1:0] o_pc,
    output logic            o_flush,
    output logic            o_redirect,
    output logic            o_misalign,
    output logic [15:0]     o_taken_cnt
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [15:0]     r_taken_cnt;
    logic            r_fetch_req;

    logic            w_in_run;
    logic            w_event;
    logic            w_aligned;
    logic            w_taken;
    logic            w_misalign;
    logic            w_adv;

    // r_fetch_req is low during reset and the cycle that follows it, which
    // also keeps the combinational redirect outputs quiet until fetch starts.
    assign w_in_run   = (r_state == ST_RUN);
    assign w_event    = r_fetch_req & w_in_run & i_ex_valid & i_ex_ctrl
                      & i_jump_cntr & ~i_stall;
    assign w_aligned  = (i_ex_target[1:0] == 2'b00);
    assign w_taken    = w_event & w_aligned;
    assign w_misalign = w_event & ~w_aligned;
    assign w_adv      = i_fetch_ack & ~i_stall;
    assign w_pc_plus4 = r_pc + PC_STEP;

`ifdef REDIRECT_BYPASS_EN
    logic [XLEN-1:0] w_target_plus4;
    assign w_target_plus4 = i_ex_target + PC_STEP;

    always_comb begin
        w_state_nxt = ST_RUN;
        w_pc_nxt    = r_pc;
        if (w_taken) begin
            // memory sees the target this cycle, so its ack is valid
            w_pc_nxt = w_adv ? w_target_plus4 : i_ex_target;
        end else if (w_adv) begin
            w_pc_nxt = w_pc_plus4;
        end
    end

    assign o_pc = w_taken ? i_ex_target : r_pc;
`else
    always_comb begin
        w_state_nxt = ST_RUN;
        w_pc_nxt    = r_pc;
        if (w_taken) begin
            // the ack in this cycle was for the wrong-path PC and is dropped
            w_pc_nxt    = i_ex_target;
            w_state_nxt = ST_FLUSH;
        end else if (w_adv) begin
            w_pc_nxt = w_pc_plus4;
        end
    end

    assign o_pc = r_pc;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_taken_cnt <= '0;
            r_fetch_req <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fetch_req <= 1'b1;
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end
        end
    end

    assign o_fetch_req = r_fetch_req;
    assign o_flush     = w_taken | (r_state == ST_FLUSH);
    assign o_redirect  = w_taken;
    assign o_misalign  = w_misalign;
    assign o_taken_cnt = r_taken_cnt;

endmodule
